// File: rtl/sdpram_be_if.sv
// rtl/sdpram_be_if.sv - write/read port bundle for the byte-enable simple dual-port RAM
interface sdpram_be_if #(
    parameter int AddrBusWidth = 32,
    parameter int DataBusWidth = 32
);
    localparam int NB = DataBusWidth / 8;

    logic [AddrBusWidth-1:0] addr_a;
    logic [NB-1:0]           we_a;
    logic [DataBusWidth-1:0] w_data_a;
    logic                    re_b;
    logic [AddrBusWidth-1:0] addr_b;
    logic [DataBusWidth-1:0] r_data_b;
    logic                    r_valid_b;
    logic                    par_err_b;

    modport master (
        output addr_a, we_a, w_data_a, re_b, addr_b,
        input  r_data_b, r_valid_b, par_err_b
    );

    modport slave (
        input  addr_a, we_a, w_data_a, re_b, addr_b,
        output r_data_b, r_valid_b, par_err_b
    );
endinterface

// File: rtl/sdpram_be.sv
// rtl/sdpram_be.sv - simple dual-port RAM with byte enables; per-lane parity when SDPRAM_PARITY_EN is defined
module sdpram_be #(
    parameter string MemoryInitFile = "none",
    parameter int    AddrBusWidth   = 32,
    parameter int    DataBusWidth   = 32,
    parameter int    MemSizeWords   = 1024,
    parameter int    ReadLatency    = 1,
    parameter int    WriteFirst     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    sdpram_be_if.slave bus
);
    localparam int NB = DataBusWidth / 8;
    localparam int AW = (MemSizeWords > 1) ? $clog2(MemSizeWords) : 1;
    localparam logic [AddrBusWidth:0] Depth = (AddrBusWidth + 1)'(MemSizeWords);

    if (DataBusWidth % 8 != 0) begin : g_bad_width
        $error("sdpram_be: DataBusWidth must be a multiple of 8");
    end
    if (ReadLatency != 1 && ReadLatency != 2) begin : g_bad_latency
        $error("sdpram_be: ReadLatency must be 1 or 2");
    end
    if (MemSizeWords <= 0 || (AddrBusWidth < 32 && MemSizeWords > (1 << AddrBusWidth))) begin : g_bad_depth
        $error("sdpram_be: MemSizeWords must be >0 and fit the address bus");
    end

    logic [DataBusWidth-1:0] mem [MemSizeWords];

    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic          wr_ok;
    logic          rd_ok;
    logic          bypass;

    assign wa     = bus.addr_a[AW-1:0];
    assign ra     = bus.addr_b[AW-1:0];
    assign wr_ok  = rst_n && ({1'b0, bus.addr_a} < Depth);
    assign rd_ok  = {1'b0, bus.addr_b} < Depth;
    assign bypass = (WriteFirst != 0) && wr_ok && (bus.addr_a == bus.addr_b);

`ifdef SDPRAM_PARITY_EN
    logic [NB-1:0] par_mem [MemSizeWords];

    function automatic logic [NB-1:0] lane_par(input logic [DataBusWidth-1:0] d);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction
`endif

    // Byte-lane write port; array (and parity bits) keep their contents through reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.we_a[i]) begin
                    mem[wa][8*i +: 8] <= bus.w_data_a[8*i +: 8];
`ifdef SDPRAM_PARITY_EN
                    par_mem[wa][i] <= ^bus.w_data_a[8*i +: 8];
`endif
                end
            end
        end
    end

    logic [DataBusWidth-1:0] rd_word;

    // Read word before the edge: old content, written lanes replaced when write-first bypass applies
    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = mem[ra];
            if (bypass) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.we_a[i]) rd_word[8*i +: 8] = bus.w_data_a[8*i +: 8];
                end
            end
        end
    end

    logic                    s1_valid;
    logic [DataBusWidth-1:0] s1_data;
    logic                    s1_err;

`ifdef SDPRAM_PARITY_EN
    logic [NB-1:0] rd_par;
    logic [NB-1:0] s1_par;

    // Stored parity for the read word; bypassed lanes get freshly computed parity so they never flag
    always_comb begin
        rd_par = '0;
        if (rd_ok) begin
            rd_par = par_mem[ra];
            if (bypass) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.we_a[i]) rd_par[i] = ^bus.w_data_a[8*i +: 8];
                end
            end
        end
    end

    // Parity register travelling with the first read stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_par <= '0;
        end else if (bus.re_b) begin
            s1_par <= rd_par;
        end
    end

    assign s1_err = s1_valid && ((s1_par ^ lane_par(s1_data)) != '0);
`else
    assign s1_err = 1'b0;
`endif

    // First read stage: the registered RAM output, only updated by an accepted read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= bus.re_b;
            if (bus.re_b) s1_data <= rd_word;
        end
    end

    if (ReadLatency == 2) begin : g_rl2
        logic                    out_valid;
        logic [DataBusWidth-1:0] out_data;
        logic                    out_err;

        // Extra output register; the in-flight word was captured at stage one and is not re-read
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid <= 1'b0;
                out_data  <= '0;
                out_err   <= 1'b0;
            end else begin
                out_valid <= s1_valid;
                out_err   <= s1_err;
                if (s1_valid) out_data <= s1_data;
            end
        end

        assign bus.r_valid_b = out_valid;
        assign bus.r_data_b  = out_data;
        assign bus.par_err_b = out_valid && out_err;
    end else begin : g_rl1
        assign bus.r_valid_b = s1_valid;
        assign bus.r_data_b  = s1_data;
        assign bus.par_err_b = s1_err;
    end
endmodule
